epmp_mem_resp: RTL and testbench

EPMP_MEM_RESP -- requirements
Module: epmp_mem_resp

---
 rtl/epmp_mem_pkg.sv | 19 +
 rtl/epmp_mem_array.sv | 23 ++
 rtl/epmp_mem_resp.sv | 109 ++++++++++
 tb/tb_epmp_mem_resp.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/epmp_mem_pkg.sv
// Shared constants and FSM state codes for the EPMP external memory responder.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package epmp_mem_pkg;

    localparam int ADDR_W          = 8;
    localparam int DATA_W          = 8;
    localparam int WCNT_W          = 3;
    localparam int MAX_WAIT_STATES = 7;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WAIT   = 3'd1,
        ST_ACCESS = 3'd2,
        ST_DONE   = 3'd3,
        ST_ERR    = 3'd4
    } mem_state_e;

endpackage

// File: rtl/epmp_mem_array.sv
// 256x8 storage: synchronous write, registered read, contents never reset.
// Latency: read data valid one clk after rd_en; write lands on the same edge.
// Backpressure: none, accepts one read and one write per cycle.
module epmp_mem_array
    import epmp_mem_pkg::*;
(
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_dat,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_dat
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_dat;
        if (rd_en) rd_dat <= mem[rd_addr];
    end

endmodule

// File: rtl/epmp_mem_resp.sv
// CPU-facing memory responder; optional write-protect below ROM_TOP via EPMP_MEM_ROM_PROTECT_EN.
// Latency: Ready rises WAIT_STATES+1 edges after the request-sampling edge.
// Backpressure: four-phase; DONE/ERR hold until Read and Write are both low.
module epmp_mem_resp
    import epmp_mem_pkg::*;
#(
    parameter int                WAIT_STATES = 2,
    parameter logic [ADDR_W-1:0] ROM_TOP     = 8'h3F
) (
    input  logic              clk,
    input  logic              nReset,
    input  logic [ADDR_W-1:0] Addr,
    input  logic [DATA_W-1:0] Data_In,
    input  logic              Read,
    input  logic              Write,
    output logic [DATA_W-1:0] Data_Out,
    output logic              Ready,
    output logic              Busy,
    output logic              Bus_Err,
    output logic [2:0]        Debug_Mem_State
);

`ifdef EPMP_MEM_ROM_PROTECT_EN
    localparam bit ROM_PROTECT = 1'b1;
`else
    localparam bit ROM_PROTECT = 1'b0;
`endif

    // Out-of-range settings saturate rather than wrap the 3-bit counter.
    localparam int WS_EFF = (WAIT_STATES > MAX_WAIT_STATES) ? MAX_WAIT_STATES : WAIT_STATES;
    localparam logic [WCNT_W-1:0] WAIT_LAST = (WS_EFF == 0) ? '0 : WCNT_W'(WS_EFF - 1);

    mem_state_e        state_q, state_d;
    logic [WCNT_W-1:0] wcnt_q;
    logic [ADDR_W-1:0] addr_q, rd_addr;
    logic [DATA_W-1:0] dat_q, rd_dat;
    logic              req_wr_q;
    logic              rom_hit, wr_en, rd_en, ld_dout, err_pulse;

    wire req_any = Read | Write;
    wire req_one = Read ^ Write;

    assign rom_hit = ROM_PROTECT && req_wr_q && (addr_q <= ROM_TOP);

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) state_q <= ST_IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (Read && Write) state_d = ST_ERR;
                else if (req_one)  state_d = (WS_EFF == 0) ? ST_ACCESS : ST_WAIT;
            end
            ST_WAIT:   if (wcnt_q == WAIT_LAST) state_d = ST_ACCESS;
            ST_ACCESS: state_d = ST_DONE;
            ST_DONE:   if (!req_any) state_d = ST_IDLE;
            ST_ERR:    if (!req_any) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        Busy            = (state_q != ST_IDLE);
        Debug_Mem_State = state_q;
        // Array read is issued on the edge entering ACCESS so Data_Out can load on the edge leaving it.
        rd_addr   = (state_q == ST_IDLE) ? Addr : addr_q;
        rd_en     = (state_d == ST_ACCESS) && ((state_q == ST_IDLE) ? Read : !req_wr_q);
        ld_dout   = (state_q == ST_ACCESS) && !req_wr_q;
        wr_en     = (state_q == ST_ACCESS) && req_wr_q && !rom_hit;
        err_pulse = ((state_q == ST_IDLE) && (state_d == ST_ERR)) ||
                    ((state_q == ST_ACCESS) && rom_hit);
    end

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            wcnt_q   <= '0;
            addr_q   <= '0;
            dat_q    <= '0;
            req_wr_q <= 1'b0;
            Data_Out <= '0;
            Ready    <= 1'b0;
            Bus_Err  <= 1'b0;
        end else begin
            wcnt_q <= (state_q == ST_WAIT) ? wcnt_q + 1'b1 : '0;
            if ((state_q == ST_IDLE) && (state_d != ST_IDLE)) begin
                addr_q   <= Addr;
                dat_q    <= Data_In;
                req_wr_q <= Write;
            end
            if (ld_dout) Data_Out <= rd_dat;
            Ready   <= (state_d == ST_DONE);
            Bus_Err <= err_pulse;
        end
    end

    epmp_mem_array u_array (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (addr_q),
        .wr_dat  (dat_q),
        .rd_en   (rd_en),
        .rd_addr (rd_addr),
        .rd_dat  (rd_dat)
    );

endmodule

// File: tb/tb_epmp_mem_resp.sv
// Directed bench for epmp_mem_resp: WAIT_STATES=2 (dut_a) and WAIT_STATES=0 (dut_b) side by side.
// Expected read data comes from a reference memory and is queued at request time.
module tb_epmp_mem_resp;

`ifdef EPMP_MEM_ROM_PROTECT_EN
    localparam bit ROM_EN = 1'b1;
`else
    localparam bit ROM_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       nReset;
    logic [7:0] addr, din;
    logic       rd_a, wr_a, rd_b, wr_b;
    logic [7:0] dout_a, dout_b;
    logic       ready_a, ready_b, busy_a, busy_b, berr_a, berr_b;
    logic [2:0] st_a, st_b;

    logic       sel;
    logic [7:0] m_dout;
    logic       m_ready, m_busy, m_berr;
    logic [2:0] m_st;

    int checks   = 0;
    int failures = 0;

    logic [7:0] model [2][256];
    logic [7:0] last_dout [2];
    logic [7:0] sb_q [$];

    always #5 clk = ~clk;

    epmp_mem_resp #(.WAIT_STATES(2), .ROM_TOP(8'h3F)) dut_a (
        .clk(clk), .nReset(nReset), .Addr(addr), .Data_In(din), .Read(rd_a), .Write(wr_a),
        .Data_Out(dout_a), .Ready(ready_a), .Busy(busy_a), .Bus_Err(berr_a), .Debug_Mem_State(st_a)
    );

    epmp_mem_resp #(.WAIT_STATES(0), .ROM_TOP(8'h3F)) dut_b (
        .clk(clk), .nReset(nReset), .Addr(addr), .Data_In(din), .Read(rd_b), .Write(wr_b),
        .Data_Out(dout_b), .Ready(ready_b), .Busy(busy_b), .Bus_Err(berr_b), .Debug_Mem_State(st_b)
    );

    always_comb begin
        m_dout  = sel ? dout_b  : dout_a;
        m_ready = sel ? ready_b : ready_a;
        m_busy  = sel ? busy_b  : busy_a;
        m_berr  = sel ? berr_b  : berr_a;
        m_st    = sel ? st_b    : st_a;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input bit s, input logic r, input logic w);
        if (s) begin rd_b = r; wr_b = w; end
        else   begin rd_a = r; wr_a = w; end
    endtask

    // One four-phase access; hold = extra cycles Read/Write stay high after Ready.
    task automatic access(input bit s, input bit is_wr, input logic [7:0] a,
                          input logic [7:0] d, input int hold);
        int         edges;
        bit         prot;
        logic [7:0] exp_d;
        prot = ROM_EN && is_wr && (a <= 8'h3F);
        sel  = s;
        @(negedge clk);
        addr = a; din = d;
        set_req(s, !is_wr, is_wr);
        if (!is_wr) sb_q.push_back(model[s][a]);
        @(posedge clk); #1;
        check("busy_after_sample", m_busy, 1);
        check("ready_low_after_sample", m_ready, 0);
        addr = ~a; din = ~d;
        edges = 0;
        do begin
            @(posedge clk); #1;
            edges++;
        end while (!m_ready && edges < 20);
        check("ready_latency", edges, s ? 1 : 3);
        check("state_done", m_st, 3);
        check("bus_err_at_ready", m_berr, prot);
        if (!is_wr) begin
            exp_d = sb_q.pop_front();
            check("read_data", m_dout, exp_d);
            last_dout[s] = exp_d;
        end else begin
            check("dout_kept_on_write", m_dout, last_dout[s]);
            if (!prot) model[s][a] = d;
        end
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check("hold_ready", m_ready, 1);
            check("hold_state", m_st, 3);
            check("hold_bus_err", m_berr, 0);
            check("hold_dout", m_dout, last_dout[s]);
        end
        @(negedge clk);
        set_req(s, 1'b0, 1'b0);
        @(posedge clk); #1;
        check("ready_drop", m_ready, 0);
        check("idle_after_drop", m_st, 0);
        check("bus_err_clear", m_berr, 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_dout_a"}, dout_a, 0);
        check({tag, "_ready_a"}, ready_a, 0);
        check({tag, "_busy_a"}, busy_a, 0);
        check({tag, "_berr_a"}, berr_a, 0);
        check({tag, "_state_a"}, st_a, 0);
        check({tag, "_dout_b"}, dout_b, 0);
        check({tag, "_ready_b"}, ready_b, 0);
        check({tag, "_busy_b"}, busy_b, 0);
        check({tag, "_berr_b"}, berr_b, 0);
        check({tag, "_state_b"}, st_b, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "simulation did not finish");
    end

    initial begin
        nReset = 1'b0;
        addr = '0; din = '0;
        rd_a = 0; wr_a = 0; rd_b = 0; wr_b = 0;
        sel = 1'b0;
        last_dout[0] = 8'h00;
        last_dout[1] = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        nReset = 1'b1;

        // Write then read back with two wait states.
        access(0, 1, 8'h80, 8'hA5, 0);
        access(0, 0, 8'h80, 8'h00, 0);

        // Zero wait states.
        access(1, 1, 8'h10, 8'h3C, 0);
        access(1, 0, 8'h10, 8'h00, 0);

        // Address extremes are distinct locations.
        access(0, 1, 8'h00, 8'h11, 0);
        access(0, 1, 8'hFF, 8'h22, 0);
        access(0, 0, 8'h00, 8'h00, 0);
        access(0, 0, 8'hFF, 8'h00, 0);
        access(0, 0, 8'h80, 8'h00, 0);

        // Low-region write: blocked with Bus_Err only when protection is built in.
        access(0, 1, 8'h20, 8'hFF, 0);
        access(0, 0, 8'h20, 8'h00, 0);

        // Read and Write together: one Bus_Err pulse, no array access.
        access(0, 1, 8'h60, 8'h55, 0);
        sel = 1'b0;
        @(negedge clk);
        addr = 8'h60; din = 8'hEE; rd_a = 1; wr_a = 1;
        @(posedge clk); #1;
        check("err_state", st_a, 4);
        check("err_pulse", berr_a, 1);
        check("err_ready", ready_a, 0);
        check("err_busy", busy_a, 1);
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            check("err_pulse_single", berr_a, 0);
            check("err_ready_low", ready_a, 0);
            check("err_state_hold", st_a, 4);
        end
        @(negedge clk);
        rd_a = 0;
        @(posedge clk); #1;
        check("err_hold_one_req", st_a, 4);
        check("err_ready_one_req", ready_a, 0);
        @(negedge clk);
        wr_a = 0;
        @(posedge clk); #1;
        check("err_to_idle", st_a, 0);
        access(0, 0, 8'h60, 8'h00, 0);

        // Read held after Ready: DONE persists, no second access.
        access(0, 0, 8'h80, 8'h00, 4);

        // Reset during WAIT of a write.
        access(0, 1, 8'h90, 8'h5A, 0);
        access(0, 0, 8'h90, 8'h00, 0);
        @(negedge clk);
        addr = 8'h90; din = 8'h77; wr_a = 1;
        @(posedge clk); #1;
        check("rst_in_wait", st_a, 1);
        #2 nReset = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        last_dout[0] = 8'h00;
        last_dout[1] = 8'h00;
        @(negedge clk);
        wr_a = 0;
        @(negedge clk);
        nReset = 1'b1;
        @(posedge clk); #1;
        check("no_resume_after_reset", st_a, 0);
        access(0, 0, 8'h90, 8'h00, 0);
        access(1, 0, 8'h10, 8'h00, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
